// File: rtl/reqrsp_mem_pkg.sv
// Shared types and limits for the request/response to memory bridge.
// Holds the response FIFO entry type, the default channel structs used when
// the bridge is instantiated without explicit request/response types, and
// the upper bound on memory read latency.
package reqrsp_mem_pkg;

   localparam int unsigned MAX_MEM_LATENCY = 4;

   // Response FIFO entry at the default 64-bit data width.
   typedef struct packed {
      logic [63:0] data;
      logic        error;
   } rsp_entry_t;

   // Default request channel payload (32-bit address, 64-bit data).
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [63:0] data;
      logic [7:0]  strb;
   } req_chan_t;

   typedef struct packed {
      logic      q_valid;
      req_chan_t q;
      logic      p_ready;
   } req_default_t;

   // Default response channel payload.
   typedef struct packed {
      logic [63:0] data;
      logic        error;
   } rsp_chan_t;

   typedef struct packed {
      logic      q_ready;
      logic      p_valid;
      rsp_chan_t p;
   } resp_default_t;

endpackage

// File: rtl/reqrsp_rsp_fifo.sv
// Response FIFO for the request/response to memory bridge.
// DEPTH entries of entry_t, registered head, push and pop in the same cycle
// both take effect. The caller guarantees no push when full and no pop when
// empty, so neither case is guarded here.
module reqrsp_rsp_fifo
   import reqrsp_mem_pkg::*;
#(
   parameter int unsigned DEPTH   = 2,
   parameter type         entry_t = rsp_entry_t
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   push,
   input  logic   pop,
   output logic   full,
   output logic   empty,
   input  entry_t wdata,
   output entry_t rdata
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      FILL_W   = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
   localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);

   entry_t             store [DEPTH];
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr;
   logic [FILL_W-1:0]  fill;

   assign full  = (fill == FULL_CNT);
   assign empty = (fill == '0);
   assign rdata = store[rptr];

   // Storage, wrapping pointers and fill level; everything clears on reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr <= '0;
         rptr <= '0;
         fill <= '0;
         for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      end else begin
         if (push) begin
            store[wptr] <= wdata;
            wptr        <= (wptr == LAST) ? '0 : wptr + 1'b1;
         end
         if (pop) rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

endmodule

// File: rtl/reqrsp_to_mem_pipe.sv
// Request/response channel to single-port memory bridge.
// Requests are issued straight to memory when credit is available; each
// accepted request travels a MEM_LATENCY-deep tag pipeline and lands in an
// in-order response FIFO sized to the outstanding limit, so a response push
// never finds the FIFO full.
// Optional build macro REQRSP_MEM_RANGE_CHECK_EN: requests outside
// [MEM_BASE, MEM_BASE+MEM_SIZE) are accepted without touching memory and
// answered with error=1, data=0 at the normal latency.
module reqrsp_to_mem_pipe
   import reqrsp_mem_pkg::*;
#(
   parameter type         req_t           = req_default_t,
   parameter type         resp_t          = resp_default_t,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned MEM_LATENCY     = 1,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [63:0] MEM_BASE        = 64'd0,
   parameter logic [63:0] MEM_SIZE        = 64'd1 << ADDR_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  req_t                    req_i,
   output resp_t                   resp_o,
   output logic                    mem_req,
   input  logic                    mem_gnt,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   // Latency is clamped into the supported 1..MAX_MEM_LATENCY range.
   localparam int unsigned LAT = (MEM_LATENCY < 1) ? 1 :
                                 (MEM_LATENCY > MAX_MEM_LATENCY) ? MAX_MEM_LATENCY : MEM_LATENCY;
   localparam int unsigned       CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  error;
   } entry_t;

   logic [CNT_W-1:0] cnt;
   logic             credit;
   logic             in_range;
   logic             err_in;
   logic             q_ready;
   logic             accept;
   logic             p_hs;
   logic [LAT-1:0]   vld_p;
   logic [LAT-1:0]   wr_p;
   logic [LAT-1:0]   err_p;
   entry_t           push_entry;
   entry_t           head;
   logic             fifo_empty;
   logic             full_unused;

`ifdef REQRSP_MEM_RANGE_CHECK_EN
   logic [63:0] addr_ext;
   assign addr_ext = 64'(req_i.q.addr);
   assign in_range = (addr_ext >= MEM_BASE) && (addr_ext < MEM_BASE + MEM_SIZE);
   assign err_in   = ~in_range;
`else
   // Whole address space is legal; the window bounds have no effect.
   logic window_unused;
   assign window_unused = |(MEM_BASE ^ MEM_SIZE);
   assign in_range      = 1'b1;
   assign err_in        = 1'b0;
`endif

   assign credit  = (cnt < MAX_CNT);
   assign q_ready = credit & (mem_gnt | ~in_range);
   assign accept  = req_i.q_valid & q_ready;
   assign p_hs    = ~fifo_empty & req_i.p_ready;

   // Memory is never requested while reset is held.
   assign mem_req   = ~rst_i & req_i.q_valid & credit & in_range;
   assign mem_we    = mem_req & req_i.q.write;
   assign mem_addr  = req_i.q.addr;
   assign mem_wdata = req_i.q.data;
   assign mem_be    = req_i.q.strb;

   // Outstanding count: +1 on accept, -1 on response handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else begin
         case ({accept, p_hs})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Tag pipeline aligning each accept with its read data LAT cycles later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_p <= '0;
         wr_p  <= '0;
         err_p <= '0;
      end else begin
         vld_p[0] <= accept;
         wr_p[0]  <= req_i.q.write;
         err_p[0] <= err_in;
         for (int i = 1; i < LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
            wr_p[i]  <= wr_p[i-1];
            err_p[i] <= err_p[i-1];
         end
      end
   end

   // Writes and rejected accesses return zero data; reads return memory data.
   always_comb begin
      push_entry       = '0;
      push_entry.error = err_p[LAT-1];
      push_entry.data  = (wr_p[LAT-1] | err_p[LAT-1]) ? '0 : mem_rdata;
   end

   reqrsp_rsp_fifo #(
      .DEPTH   (MAX_OUTSTANDING),
      .entry_t (entry_t)
   ) u_rsp_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (vld_p[LAT-1]),
      .pop   (p_hs),
      .full  (full_unused),
      .empty (fifo_empty),
      .wdata (push_entry),
      .rdata (head)
   );

   // Response channel assembly from the credit logic and the FIFO head.
   always_comb begin
      resp_o         = '0;
      resp_o.q_ready = q_ready;
      resp_o.p_valid = ~fifo_empty;
      resp_o.p.data  = head.data;
      resp_o.p.error = head.error;
   end

endmodule

// File: tb/tb_reqrsp_to_mem_pipe.sv
// Bench for reqrsp_to_mem_pipe: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model (a queue of
// expected responses, each tagged with the cycle it becomes visible).
// Build with REQRSP_MEM_RANGE_CHECK_EN defined to exercise the address window.
module tb_reqrsp_to_mem_pipe;
   import reqrsp_mem_pkg::*;

   localparam int unsigned ML   = 1;
   localparam int unsigned MAXO = 4;
`ifdef REQRSP_MEM_RANGE_CHECK_EN
   localparam bit          CHECK_EN = 1'b1;
   localparam logic [63:0] BASE     = 64'h1000;
   localparam logic [63:0] SIZE     = 64'h1000;
   localparam logic [31:0] OFS      = 32'h1000;
`else
   localparam bit          CHECK_EN = 1'b0;
   localparam logic [63:0] BASE     = 64'h0;
   localparam logic [63:0] SIZE     = 64'h1_0000_0000;
   localparam logic [31:0] OFS      = 32'h0;
`endif

   logic          clk = 1'b0;
   logic          rst_i;
   req_default_t  req;
   resp_default_t resp;
   logic          mem_req, mem_gnt, mem_we;
   logic [7:0]    mem_be;
   logic [31:0]   mem_addr;
   logic [63:0]   mem_wdata, mem_rdata;

   typedef struct {
      logic [63:0] data;
      logic        error;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] sched[int];
   int          cyc;
   int          errors;
   int          checks;

   always #5 clk = ~clk;

   reqrsp_to_mem_pipe #(
      .req_t           (req_default_t),
      .resp_t          (resp_default_t),
      .DATA_WIDTH      (64),
      .ADDR_WIDTH      (32),
      .MEM_LATENCY     (ML),
      .MAX_OUTSTANDING (MAXO),
      .MEM_BASE        (BASE),
      .MEM_SIZE        (SIZE)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .req_i     (req),
      .resp_o    (resp),
      .mem_req   (mem_req),
      .mem_gnt   (mem_gnt),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic in_window(input logic [31:0] a);
      return !CHECK_EN || ((64'(a) >= BASE) && (64'(a) < BASE + SIZE));
   endfunction

   // One clock cycle: drive inputs, compare against the model, advance the model.
   task automatic step(input logic qv, input logic [31:0] addr, input logic wr,
                       input logic [63:0] wd, input logic [7:0] sb, input logic pr,
                       input logic gnt, input logic [63:0] rv);
      logic inr, exp_rdy, exp_mreq, exp_pv;
      exp_t e;
      @(negedge clk);
      req.q_valid  = qv;
      req.q.addr   = addr;
      req.q.write  = wr;
      req.q.data   = wd;
      req.q.strb   = sb;
      req.p_ready  = pr;
      mem_gnt      = gnt;
      mem_rdata    = sched.exists(cyc) ? sched[cyc] : {$urandom(), $urandom()};
      #1;
      inr      = in_window(addr);
      exp_rdy  = (exp_q.size() < MAXO) && (gnt || !inr);
      exp_mreq = qv && (exp_q.size() < MAXO) && inr;
      exp_pv   = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      check_val("q_ready", 64'(resp.q_ready), 64'(exp_rdy));
      check_val("mem_req", 64'(mem_req), 64'(exp_mreq));
      if (exp_mreq) begin
         check_val("mem_we", 64'(mem_we), 64'(wr));
         check_val("mem_be", 64'(mem_be), 64'(sb));
         check_val("mem_addr", 64'(mem_addr), 64'(addr));
         check_val("mem_wdata", mem_wdata, wd);
      end
      check_val("p_valid", 64'(resp.p_valid), 64'(exp_pv));
      if (exp_pv) begin
         check_val("p_data", resp.p.data, exp_q[0].data);
         check_val("p_error", 64'(resp.p.error), 64'(exp_q[0].error));
         if (pr) void'(exp_q.pop_front());
      end
      if (qv && exp_rdy) begin
         e.due = cyc + ML + 1;
         if (!inr) begin
            e.data = '0; e.error = 1'b1;
         end else if (wr) begin
            e.data = '0; e.error = 1'b0;
         end else begin
            e.data = rv; e.error = 1'b0;
            sched[cyc + ML] = rv;
         end
         exp_q.push_back(e);
      end
      if (sched.exists(cyc)) sched.delete(cyc);
      cyc++;
   endtask

   task automatic idle(input int n, input logic pr);
      for (int i = 0; i < n; i++) step(1'b0, OFS, 1'b0, '0, '0, pr, 1'b1, '0);
   endtask

   task automatic rd(input logic [31:0] a, input logic pr, input logic gnt, input logic [63:0] v);
      step(1'b1, a, 1'b0, {$urandom(), $urandom()}, 8'hFF, pr, gnt, v);
   endtask

   // Asynchronous reset entry with a live request on the channel.
   task automatic reset_phase();
      rst_i       = 1'b1;
      req.q_valid = 1'b1;
      req.q.addr  = OFS + 32'h100;
      req.q.write = 1'b0;
      req.p_ready = 1'b1;
      mem_gnt     = 1'b0;
      #1;
      check_val("rst_p_valid", 64'(resp.p_valid), 64'd0);
      check_val("rst_mem_req", 64'(mem_req), 64'd0);
      check_val("rst_q_ready_nognt", 64'(resp.q_ready), 64'd0);
      mem_gnt = 1'b1;
      #1;
      check_val("rst_q_ready_gnt", 64'(resp.q_ready), 64'd1);
      check_val("rst_mem_req_gnt", 64'(mem_req), 64'd0);
      repeat (3) @(negedge clk);
      check_val("rst_hold_p_valid", 64'(resp.p_valid), 64'd0);
      rst_i       = 1'b0;
      req.q_valid = 1'b0;
      mem_gnt     = 1'b0;
      exp_q.delete();
      sched.delete();
      cyc += 4;
   endtask

   initial begin
      logic [31:0] a;
      errors = 0;
      checks = 0;
      cyc    = 0;
      req    = '0;
      mem_gnt   = 1'b0;
      mem_rdata = '0;
      rst_i     = 1'b1;
      @(negedge clk);
      reset_phase();

      // Single read, latency MEM_LATENCY+1.
      rd(OFS + 32'h100, 1'b0, 1'b1, 64'hDEAD_BEEF);
      idle(1, 1'b0);
      idle(1, 1'b1);
      check_val("single_rd_data", resp.p.data, 64'hDEAD_BEEF);
      idle(2, 1'b1);

      // Write with partial strobes.
      step(1'b1, OFS + 32'h40, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, 1'b1, 1'b1, '0);
      check_val("wr_mem_we", 64'(mem_we), 64'd1);
      check_val("wr_mem_be", 64'(mem_be), 64'h0F);
      idle(3, 1'b1);

      // Grant withheld for 3 cycles, then accepted on the first granted cycle.
      for (int i = 0; i < 3; i++) rd(OFS + 32'h200, 1'b1, 1'b0, 64'h0BAD);
      rd(OFS + 32'h200, 1'b1, 1'b1, 64'hC0FFEE);
      idle(3, 1'b1);

      // Back-to-back reads under backpressure: 4 accepted, 5th refused.
      for (int i = 0; i < 5; i++) rd(OFS + 32'h300 + 32'(i * 8), 1'b0, 1'b1, 64'hA000 + 64'(i));
      idle(3, 1'b0);
      idle(6, 1'b1);

`ifdef REQRSP_MEM_RANGE_CHECK_EN
      // Window boundaries: 0x2000 and 0x0FFF rejected, 0x1FFF and 0x1000 served.
      rd(32'h2000, 1'b1, 1'b1, 64'h5555);
      rd(32'h0FFF, 1'b1, 1'b0, 64'h6666);
      rd(32'h1FFF, 1'b1, 1'b1, 64'h7777);
      rd(32'h1000, 1'b1, 1'b1, 64'h8888);
      idle(4, 1'b1);
`endif

      // Reset with two requests in flight: nothing may surface afterwards.
      rd(OFS + 32'h500, 1'b0, 1'b1, 64'h1);
      rd(OFS + 32'h508, 1'b0, 1'b1, 64'h2);
      idle(2, 1'b0);
      reset_phase();
      idle(5, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         a = OFS - 32'h100 + 32'($urandom_range(0, 32'h11FF));
         step(($urandom_range(0, 3) != 0), a, $urandom_range(0, 1) == 1,
              {$urandom(), $urandom()}, 8'($urandom()),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
              {$urandom(), $urandom()});
      end

      // Drain with a bounded budget.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1, 1'b1);
      check_val("drain_empty", 64'(exp_q.size()), 64'd0);
      idle(2, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reqrsp_to_mem_pipe.md
REQRSP_TO_MEM_PIPE -- requirements
Module: reqrsp_to_mem_pipe

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  - req_t, logic: request struct; fields q_valid, q.addr, q.write, q.data, q.strb, p_ready.
  - resp_t, logic: response struct; fields q_ready, p_valid, p.data, p.error.
  - DATA_WIDTH, 64: data width, a multiple of 8.
  - ADDR_WIDTH, 32: address width.
  - MEM_LATENCY, 1: cycles from grant to rdata valid; legal range 1..4.
  - MAX_OUTSTANDING, 2: maximum accepted but unretired requests; power of two, >= 1.
  - MEM_BASE, 0: base of the legal address window.
  - MEM_SIZE, 2**ADDR_WIDTH: size of the window in bytes.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  - clk_i, in, 1: the single clock.
  - rst_i, in, 1: reset; asynchronous, active-high.
  - req_i, in, req_t: request channel.
  - resp_o, out, resp_t: response channel.
  - mem_req, out, 1: memory access request.
  - mem_gnt, in, 1: memory grant.
  - mem_we, out, 1: write enable.
  - mem_be, out, DATA_WIDTH/8: byte enables.
  - mem_addr, out, ADDR_WIDTH: address.
  - mem_wdata, out, DATA_WIDTH: write data.
  - mem_rdata, in, DATA_WIDTH: read data, valid MEM_LATENCY cycles after grant.

Function
REQ-003 Outstanding counter cnt (width $clog2(MAX_OUTSTANDING+1)) SHALL count accepted requests whose response has not yet handshaken on p.
REQ-004 credit SHALL be (cnt < MAX_OUTSTANDING).
REQ-005 Issue path SHALL drive mem_req = q_valid & credit & in_range.
REQ-006 Issue path SHALL drive q_ready = credit & (mem_gnt | ~in_range).
REQ-007 accept SHALL be q_valid & q_ready.
REQ-008 mem_we SHALL equal mem_req & q.write; mem_addr, mem_wdata and mem_be SHALL pass through q.addr, q.data and q.strb combinationally.
REQ-009 On accept cnt SHALL increment; on p handshake (p_valid & p_ready) cnt SHALL decrement; when both occur in the same cycle cnt SHALL be unchanged.
REQ-010 Each accept SHALL enter a MEM_LATENCY-stage shift pipeline carrying {valid, write, err}; back-to-back accepts on consecutive cycles SHALL be supported.
REQ-011 When a stage-final entry is valid it SHALL push into the response FIFO {data, error}. data SHALL be mem_rdata for an in-range read and all zeros for a write or an error; error SHALL be err.
REQ-012 The response FIFO SHALL have MAX_OUTSTANDING entries; credit gating SHALL guarantee a push never finds it full.
REQ-013 p_valid SHALL equal FIFO non-empty, and p.data and p.error SHALL be the FIFO head.
REQ-014 Responses SHALL be returned strictly in acceptance order.
REQ-015 Minimum latency from accept to p_valid SHALL be MEM_LATENCY+1 cycles (FIFO registered); a push and a pop in the same cycle SHALL both take effect.
REQ-016 When p_ready is low, the FIFO SHALL absorb all in-flight responses; no data SHALL be lost or reordered.
REQ-017 Pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-018 With MAX_OUTSTANDING=1, behaviour SHALL be strictly one request at a time.

Reset
REQ-019 Asserting rst_i SHALL immediately clear cnt, the pipeline valids, FIFO pointers and FIFO data.
REQ-020 During and after reset, resp_o.p_valid SHALL be 0 and mem_req SHALL be 0; resp_o.q_ready SHALL be 0 only while mem_gnt is 0.
REQ-021 Reset mid-operation SHALL discard all in-flight transactions; no stale response SHALL appear after release.

Configuration
REQ-022 With REQRSP_MEM_RANGE_CHECK_EN defined, in_range SHALL be (q.addr >= MEM_BASE) & (q.addr < MEM_BASE+MEM_SIZE). Out-of-range requests SHALL be accepted without mem_req, SHALL respond with error=1 and data=0, and SHALL keep the same latency and ordering.
REQ-023 Without REQRSP_MEM_RANGE_CHECK_EN, in_range SHALL be constant 1 and error SHALL always be 0.

Structure
REQ-024 Package reqrsp_mem_pkg SHALL hold the FIFO entry typedef (data, error) and the MEM_LATENCY bound constant MAX_MEM_LATENCY=4.
REQ-025 The response FIFO SHALL be sub-module reqrsp_rsp_fifo (parameters DEPTH and entry type; ports push, pop, full, empty, wdata, rdata).

Verification
REQ-026 Scenario: single read at 0x100, mem_rdata=0xDEADBEEF, MEM_LATENCY=1, p_ready=1 -> p_valid 2 cycles after accept with data 0xDEADBEEF and error 0.
REQ-027 Scenario: 4 back-to-back reads with MAX_OUTSTANDING=4 and p_ready=0 -> 4 accepts, 5th q_ready=0; raising p_ready returns 4 responses in order.
REQ-028 Scenario: write to 0x40 with strb 0x0F -> mem_we=1 and mem_be=0x0F; response data=0 and error=0.
REQ-029 Scenario: mem_gnt held 0 for 3 cycles -> q_ready=0 throughout, cnt unchanged; accept on the first granted cycle.
REQ-030 Scenario: range check enabled, MEM_BASE=0x1000, MEM_SIZE=0x1000, read 0x2000 -> mem_req=0, response error=1 and data=0 after MEM_LATENCY+1 cycles.
REQ-031 Scenario: assert rst_i with 2 requests in flight -> p_valid=0 immediately; no response after release.
